// File: rtl/sw_field_core.sv
// rtl/sw_field_core.sv - one register field: flop bank with SW/HW/counter update paths and write-once lock
`ifndef SW_RO
`define SW_RO 0
`endif
`ifndef SW_RW
`define SW_RW 1
`endif
`ifndef SW_WO
`define SW_WO 2
`endif
`ifndef SW_RW1
`define SW_RW1 3
`endif
`ifndef SW_W1
`define SW_W1 4
`endif
`ifndef NA
`define NA 0
`endif
`ifndef RCLR
`define RCLR 1
`endif
`ifndef RSET
`define RSET 2
`endif
`ifndef WOCLR
`define WOCLR 1
`endif
`ifndef WOSET
`define WOSET 2
`endif
`ifndef WOT
`define WOT 3
`endif
`ifndef WZS
`define WZS 4
`endif
`ifndef WZC
`define WZC 5
`endif
`ifndef WZT
`define WZT 6
`endif

module sw_field_core #(
  parameter int                 F_WIDTH         = 4,
  parameter int                 SW_CNT          = 1,
  parameter int                 SW_TYPE         = `SW_RW,
  parameter int                 SW_ONREAD_TYPE  = `NA,
  parameter int                 SW_ONWRITE_TYPE = `NA,
  parameter bit                 PULSE           = 1'b0,
  parameter logic [F_WIDTH-1:0] RESET_VAL       = '0,
  parameter bit                 HAS_HW_WR       = 1'b0,
  parameter int                 CNT_MODE        = 0,
  parameter bit                 CNT_SAT         = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SW_CNT-1:0]           sw_wr,
  input  logic [SW_CNT-1:0]           sw_rd,
  input  logic [F_WIDTH*SW_CNT-1:0]   sw_wr_data,
  input  logic                        hw_wr,
  input  logic [F_WIDTH-1:0]          hw_wr_data,
  input  logic                        cnt_en,
  output logic [F_WIDTH-1:0]          field_value,
  output logic [F_WIDTH-1:0]          sw_rd_data,
  output logic                        swmod_out,
  output logic                        swacc_out,
  output logic                        cnt_ovf,
  output logic                        locked
);

  localparam bit READABLE = (SW_TYPE == `SW_RO) || (SW_TYPE == `SW_RW) || (SW_TYPE == `SW_RW1);
  localparam bit WRITABLE = (SW_TYPE != `SW_RO);
  localparam bit ONCE     = (SW_TYPE == `SW_RW1) || (SW_TYPE == `SW_W1);
  localparam bit LEGAL    = (SW_TYPE >= 0) && (SW_TYPE <= 4) &&
                            (SW_ONREAD_TYPE >= 0) && (SW_ONREAD_TYPE <= 2) &&
                            (SW_ONWRITE_TYPE >= 0) && (SW_ONWRITE_TYPE <= 6) &&
                            (CNT_MODE >= 0) && (CNT_MODE <= 2) &&
                            (F_WIDTH >= 1) && (F_WIDTH <= 64) && (SW_CNT >= 1);
  localparam logic [F_WIDTH-1:0] ONE      = F_WIDTH'(1);
  localparam logic [F_WIDTH-1:0] ALL_ONES = '1;

  if (!LEGAL) begin : g_illegal_param
    $error("sw_field_core: illegal parameter combination");
  end

  logic [F_WIDTH-1:0] value_q, value_d;
  logic [F_WIDTH-1:0] wr_data, wr_result, cnt_next;
  logic               locked_q, ovf_q, ovf_d;
  logic               wr_accept, rd_side, hw_apply, cnt_apply, cnt_limit;

  // Scan downward so the lowest-index active port is the last assignment and wins.
  always_comb begin
    wr_data = '0;
    for (int i = SW_CNT - 1; i >= 0; i--) begin
      if (sw_wr[i]) wr_data = sw_wr_data[i*F_WIDTH +: F_WIDTH];
    end
  end

  always_comb begin
    case (SW_ONWRITE_TYPE)
      `WOCLR:  wr_result = value_q & ~wr_data;
      `WOSET:  wr_result = value_q | wr_data;
      `WOT:    wr_result = value_q ^ wr_data;
      `WZS:    wr_result = value_q | ~wr_data;
      `WZC:    wr_result = value_q & wr_data;
      `WZT:    wr_result = value_q ^ ~wr_data;
      default: wr_result = wr_data;
    endcase
  end

  always_comb begin
    cnt_next  = value_q;
    cnt_limit = 1'b0;
    if (CNT_MODE == 1) begin
      cnt_limit = (value_q == ALL_ONES);
      cnt_next  = (cnt_limit && CNT_SAT) ? value_q : value_q + ONE;
    end else if (CNT_MODE == 2) begin
      cnt_limit = (value_q == '0);
      cnt_next  = (cnt_limit && CNT_SAT) ? value_q : value_q - ONE;
    end
  end

  assign wr_accept = WRITABLE && (|sw_wr) && !(ONCE && locked_q);
  assign rd_side   = READABLE && (SW_ONREAD_TYPE != `NA) && (|sw_rd) && !wr_accept;
  assign hw_apply  = HAS_HW_WR && hw_wr && !wr_accept && !rd_side;
  assign cnt_apply = (CNT_MODE != 0) && cnt_en && !wr_accept && !rd_side && !hw_apply;

  // With PULSE the idle value is zero, so any set bit lasts exactly one cycle.
  always_comb begin
    value_d = PULSE ? '0 : value_q;
    ovf_d   = 1'b0;
    if (wr_accept) begin
      value_d = wr_result;
    end else if (rd_side) begin
      value_d = (SW_ONREAD_TYPE == `RSET) ? ALL_ONES : '0;
    end else if (hw_apply) begin
      value_d = hw_wr_data;
    end else if (cnt_apply) begin
      value_d = cnt_next;
      ovf_d   = cnt_limit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q  <= RESET_VAL;
      ovf_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      value_q  <= value_d;
      ovf_q    <= ovf_d;
      locked_q <= locked_q | (ONCE && wr_accept);
    end
  end

  assign field_value = value_q;
  assign sw_rd_data  = READABLE ? value_q : '0;
  assign swmod_out   = wr_accept || rd_side;
  assign swacc_out   = (|sw_rd) || wr_accept;
  assign cnt_ovf     = ovf_q;
  assign locked      = ONCE ? locked_q : 1'b0;

endmodule
